ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/game_pkg.sv | 22 ++
 rtl/arb_wait_counter.sv | 39 +++
 rtl/ram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module : game_pkg
// Brief  : Shared widths, arbiter state encoding and a saturating helper.
// Rev    : 1.0  initial release
// ============================================================================
package game_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [0:0] {
        PRIO0  = 1'b0,
        FORCE1 = 1'b1
    } arb_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module : arb_wait_counter
// Brief  : 8-bit saturating wait counter; counts while i_inc, else clears.
// Rev    : 1.0  initial release
// ============================================================================
module arb_wait_counter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    output logic [7:0] o_count,
    output logic [7:0] o_count_next
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = 8'd0;
        if (i_inc) begin
            count_d = sat_inc8(count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count      = count_q;
    assign o_count_next = count_d;

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_port_arbiter
// Brief  : Two-port arbiter onto one synchronous RAM with port-1 anti-starvation.
// Rev    : 1.0  initial release
// ============================================================================
module ram_port_arbiter
    import game_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut,
    output logic [7:0]        starve_cnt
);

    localparam logic [7:0] c_force_at = 8'(MAX_WAIT - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [1:0]        rd_pend_q;
    logic [1:0]        rd_pend_d;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata0_d;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata1_d;
    logic              wait_inc;
    logic [7:0]        wait_cnt;
    logic [7:0]        wait_next;

    // Grants are gated by reset so nothing reaches the RAM while it is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state_q)
                FORCE1: begin
                    if (req1) begin
                        gnt1 = 1'b1;
                    end else if (req0) begin
                        gnt0 = 1'b1;
                    end
                end
                default: begin
                    if (req0) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
            endcase
        end
    end

    assign wait_inc = req1 & ~gnt1;

    arb_wait_counter u_wait_counter (
        .clk          (clock),
        .rst          (reset),
        .i_inc        (wait_inc),
        .o_count      (wait_cnt),
        .o_count_next (wait_next)
    );

    assign starve_cnt = wait_cnt;

    // FORCE1 lasts exactly one cycle: it either serves port 1 or is abandoned.
    always_comb begin
        state_d = PRIO0;
        if ((state_q == PRIO0) && wait_inc && (wait_next >= c_force_at)) begin
            state_d = FORCE1;
        end
    end

    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        if (gnt0) begin
            ram_wEn    = we0;
            ram_addr   = addr0;
            ram_dataIn = wdata0;
        end else if (gnt1) begin
            ram_wEn    = we1;
            ram_addr   = addr1;
            ram_dataIn = wdata1;
        end
    end

    // RAM data is forwarded in the return cycle and latched for later holding.
    always_comb begin
        rd_pend_d = {gnt1 & ~we1, gnt0 & ~we0};
        rdata0_d  = rd_pend_q[0] ? ram_dataOut : rdata0_q;
        rdata1_d  = rd_pend_q[1] ? ram_dataOut : rdata1_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= PRIO0;
            rd_pend_q <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rvalid0 = rd_pend_q[0];
    assign rvalid1 = rd_pend_q[1];
    assign rdata0  = rdata0_d;
    assign rdata1  = rdata1_d;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_port_arbiter
// Brief  : Directed self-checking bench for ram_port_arbiter with a RAM model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, ram_wEn;
    logic [DATA_W-1:0] rdata0, rdata1, ram_dataIn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataOut = '0;
    logic [7:0]        starve_cnt;
    logic              ram_init = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
    logic              written [0:(1<<ADDR_W)-1];

    always #5 clock = ~clock;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut), .starve_cnt(starve_cnt)
    );

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        case (a)
            12'h010: return 32'hDEADBEEF;
            12'h001: return 32'h11110001;
            12'h002: return 32'h22220002;
            default: return 32'h0;
        endcase
    endfunction

    // Synchronous RAM, one-cycle read latency, read-before-write.
    always @(posedge clock) begin
        if (ram_init) begin
            for (int k = 0; k < (1 << ADDR_W); k++) written[k] <= 1'b0;
        end else begin
            ram_dataOut <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
            if (ram_wEn) begin
                mem[ram_addr]     <= ram_dataIn;
                written[ram_addr] <= 1'b1;
            end
        end
    end

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1; req0 = 1'b1; we0 = 1'b1; req1 = 1'b1; we1 = 1'b1;
        #1;
        checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %b exp 0", gnt0); end
        checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got %b exp 0", gnt1); end
        checks++; if (ram_wEn !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", ram_wEn); end
        checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {rvalid0, rvalid1}); end
        checks++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", rdata0, rdata1); end
        checks++; if (starve_cnt !== 8'd0) begin errors++; $display("FAIL rst_starve got %0d exp 0", starve_cnt); end
        @(negedge clock);
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_read0;
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rd0_gnt got %b%b exp 10", gnt0, gnt1); end
        checks++; if (ram_addr !== 12'h010 || ram_wEn !== 1'b0) begin errors++; $display("FAIL rd0_ram got %h/%b exp 010/0", ram_addr, ram_wEn); end
        @(negedge clock);
        req0 = 1'b0;
        #1;
        checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin errors++; $display("FAIL rd0_rvalid got %b%b exp 10", rvalid0, rvalid1); end
        checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_rdata got %h exp deadbeef", rdata0); end
        @(negedge clock);
        #1;
        checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_hold got %b/%h exp 0/deadbeef", rvalid0, rdata0); end
    endtask

    task automatic test_starvation;
        logic       exp1;
        logic [7:0] peak;
        peak = 8'd0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
            addr0 = 12'h001; addr1 = 12'h002;
            #1;
            exp1 = (i == 8) || (i == 16);
            if (starve_cnt > peak) peak = starve_cnt;
            checks++; if (gnt1 !== exp1 || gnt0 !== !exp1) begin errors++; $display("FAIL starve_gnt cyc %0d got %b%b exp %b%b", i, gnt0, gnt1, !exp1, exp1); end
            checks++; if (starve_cnt !== 8'((i - 1) % 8)) begin errors++; $display("FAIL starve_cnt cyc %0d got %0d exp %0d", i, starve_cnt, (i - 1) % 8); end
            if (i == 9) begin
                checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== 32'h22220002) begin
                    errors++; $display("FAIL starve_rd1 got %b%b/%h exp 01/22220002", rvalid0, rvalid1, rdata1); end
            end
            if (i == 10) begin
                checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h11110001 || rdata1 !== 32'h22220002) begin
                    errors++; $display("FAIL starve_rd0 got %b/%h/%h exp 1/11110001/22220002", rvalid0, rdata0, rdata1); end
            end
        end
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (peak !== 8'd7) begin errors++; $display("FAIL starve_peak got %0d exp 7", peak); end
        @(negedge clock);
    endtask

    task automatic test_write1;
        @(negedge clock);
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0FF; wdata1 = 32'h12345678;
        #1;
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL wr1_gnt got %b%b exp 01", gnt0, gnt1); end
        checks++; if (ram_wEn !== 1'b1 || ram_addr !== 12'h0FF || ram_dataIn !== 32'h12345678) begin
            errors++; $display("FAIL wr1_ram got %b/%h/%h exp 1/0ff/12345678", ram_wEn, ram_addr, ram_dataIn); end
        @(negedge clock);
        req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0FF;
        #1;
        checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL wr1_norvalid got %b exp 0", rvalid1); end
        checks++; if (gnt0 !== 1'b1 || ram_wEn !== 1'b0) begin errors++; $display("FAIL wr1_rdgnt got %b/%b exp 1/0", gnt0, ram_wEn); end
        @(negedge clock);
        req0 = 1'b0;
        #1;
        checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h12345678) begin errors++; $display("FAIL wr1_readback got %b/%h exp 1/12345678", rvalid0, rdata0); end
        checks++; if (ram_addr !== 12'h000 || ram_dataIn !== 32'h0 || ram_wEn !== 1'b0) begin
            errors++; $display("FAIL idle_ram got %h/%h/%b exp 000/0/0", ram_addr, ram_dataIn, ram_wEn); end
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h001; req1 = 1'b0;
        #1;
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_c1 gnt0 got %b exp 1", gnt0); end
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 12'h002;
        #1;
        checks++; if (gnt1 !== 1'b1 || rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== 32'h11110001) begin
            errors++; $display("FAIL b2b_c2 got g1=%b rv=%b%b d0=%h exp 1 10 11110001", gnt1, rvalid0, rvalid1, rdata0); end
        @(negedge clock);
        req1 = 1'b0; req0 = 1'b1; addr0 = 12'h001;
        #1;
        checks++; if (gnt0 !== 1'b1 || rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== 32'h22220002 || rdata0 !== 32'h11110001) begin
            errors++; $display("FAIL b2b_c3 got g0=%b rv=%b%b d1=%h d0=%h exp 1 01 22220002 11110001", gnt0, rvalid0, rvalid1, rdata1, rdata0); end
        @(negedge clock);
        req0 = 1'b0;
        #1;
        checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin errors++; $display("FAIL b2b_c4 got %b%b exp 10", rvalid0, rvalid1); end
    endtask

    task automatic test_reset_after_grant;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010; req1 = 1'b1; we1 = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1; req0 = 1'b0;
        #1;
        checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin errors++; $display("FAIL rstg_rvalid got %b/%h exp 0/0", rvalid0, rdata0); end
        checks++; if (starve_cnt !== 8'd0 || gnt1 !== 1'b0) begin errors++; $display("FAIL rstg_state got cnt=%0d g1=%b exp 0/0", starve_cnt, gnt1); end
        @(negedge clock);
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || starve_cnt !== 8'd0) begin
            errors++; $display("FAIL rstg_prio0 got %b%b cnt=%0d exp 10 cnt=0", gnt0, gnt1, starve_cnt); end
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_force_drop;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clock);
            req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
            #1;
            checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL drop_pre cyc %0d gnt0 got %b exp 1", i, gnt0); end
        end
        @(negedge clock);
        req1 = 1'b0;
        #1;
        checks++; if (gnt1 !== 1'b0 || gnt0 !== 1'b1) begin errors++; $display("FAIL drop_force got %b%b exp 10", gnt0, gnt1); end
        @(negedge clock);
        req1 = 1'b1;
        #1;
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || starve_cnt !== 8'd0) begin
            errors++; $display("FAIL drop_back got %b%b cnt=%0d exp 10 cnt=0", gnt0, gnt1, starve_cnt); end
        @(negedge clock);
        #1;
        checks++; if (gnt0 !== 1'b1 || starve_cnt !== 8'd1) begin errors++; $display("FAIL drop_count got g0=%b cnt=%0d exp 1/1", gnt0, starve_cnt); end
        @(negedge clock);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        ram_init = 1'b0;
        test_reset();
        test_read0();
        test_starvation();
        test_write1();
        test_back_to_back();
        test_reset_after_grant();
        test_force_drop();
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
